// File: rtl/decodificador_pkg.sv
`default_nettype none
// ============================================================================
// Module : decodificador_pkg
// Brief  : Shared types, constants and the hex-to-7-segment glyph function
//          for the decodificador_display block.
// Revision: 1.0 - initial release
// ============================================================================
package decodificador_pkg;

  // Active-low display idle values: every segment and every anode off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_sel_t;

  // Glyph table, returned as {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex2seg(input nibble_t val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;  // 4'hF
    endcase
    return seg;
  endfunction

  // Active-low anode enable: the selected digit's bit is the only zero.
  function automatic logic [3:0] sel2an(input digit_sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage : decodificador_pkg
`default_nettype wire

// File: rtl/decodificador_display_if.sv
`default_nettype none
// ============================================================================
// Module : decodificador_display_if
// Brief  : Board-side signal bundle of the display decoder.
//          SW0..SW3 : four 4-bit switch groups
//          BTN      : 2-bit digit/group select
//          AN       : 4-bit active-low anode enables
//          SEG      : 7-bit active-low segments, SEG[0]=a .. SEG[6]=g
//          master modport = board/stimulus side, slave modport = decoder.
// Revision: 1.0 - initial release
// ============================================================================
interface decodificador_display_if;
  import decodificador_pkg::*;

  nibble_t     SW0;
  nibble_t     SW1;
  nibble_t     SW2;
  nibble_t     SW3;
  logic [1:0]  BTN;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  modport master (
    output SW0, SW1, SW2, SW3, BTN,
    input  AN, SEG
  );

  modport slave (
    input  SW0, SW1, SW2, SW3, BTN,
    output AN, SEG
  );

endinterface : decodificador_display_if
`default_nettype wire

// File: rtl/decodificador_display_hex7seg.sv
`default_nettype none
// ============================================================================
// Module : hex7seg
// Brief  : Purely combinational nibble to active-low 7-segment decoder.
//          val : 4-bit hex value in
//          seg : 7-bit glyph out, {g,f,e,d,c,b,a}, active-low
// Revision: 1.0 - initial release
// ============================================================================
module hex7seg
  import decodificador_pkg::*;
(
  input  nibble_t    val,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex2seg(val);
  end

endmodule : hex7seg
`default_nettype wire

// File: rtl/decodificador_display.sv
`default_nettype none
// ============================================================================
// Module : decodificador_display
// Brief  : Four-group hex-to-7-segment decoder for a 4-digit common-anode
//          display with registered outputs.
//          clk  : system clock, rising edge
//          rst  : synchronous active-high reset
//          io   : decodificador_display_if.slave (SW0..SW3, BTN in; AN, SEG out)
//          Optional feature macro DECODIFICADOR_SCAN_EN: when defined, a
//          free-running SCAN_DIV_W-bit counter time-multiplexes all four
//          digits and BTN is ignored. When undefined, BTN selects the digit.
// Revision: 1.0 - initial release
// ============================================================================
module decodificador_display
  import decodificador_pkg::*;
#(
  parameter int SCAN_DIV_W = 17
) (
  input  wire logic               clk,
  input  wire logic               rst,
  decodificador_display_if.slave  io
);

  digit_sel_t sel;
  nibble_t    val;
  logic [6:0] glyph;

  logic [3:0] an_d,  an_q;
  logic [6:0] seg_d, seg_q;

`ifdef DECODIFICADOR_SCAN_EN
  // Refresh divider: the scan index advances once per full counter period,
  // so each digit stays lit for 2**SCAN_DIV_W cycles.
  localparam logic [SCAN_DIV_W-1:0] SCAN_ONE = SCAN_DIV_W'(1);

  logic [SCAN_DIV_W-1:0] scan_cnt_d, scan_cnt_q;
  digit_sel_t            scan_idx_d, scan_idx_q;

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_ONE;
    scan_idx_d = scan_idx_q;
    if (&scan_cnt_q) begin
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign sel = scan_idx_q;
`else
  // The divider width only matters for the scanning build; the empty block
  // keeps the parameter elaborated (and range-checked) in this build too.
  if (SCAN_DIV_W > 0) begin : g_scan_w_unused
  end

  assign sel = io.BTN;
`endif

  // Group mux: the value shown is the switch group matching the digit index.
  always_comb begin
    val = io.SW0;
    case (sel)
      2'd0:    val = io.SW0;
      2'd1:    val = io.SW1;
      2'd2:    val = io.SW2;
      default: val = io.SW3;
    endcase
  end

  hex7seg u_hex7seg (
    .val (val),
    .seg (glyph)
  );

  always_comb begin
    an_d  = sel2an(sel);
    seg_d = glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign io.AN  = an_q;
  assign io.SEG = seg_q;

endmodule : decodificador_display
`default_nettype wire

// File: tb/tb_decodificador_display.sv
`default_nettype none
// ============================================================================
// Module : tb_decodificador_display
// Brief  : Self-checking bench for decodificador_display. Expected AN/SEG come
//          from a table of glyphs and the digit-select rule, applied to the
//          stimulus the bench itself drove. With DECODIFICADOR_SCAN_EN defined
//          the scan sequence is checked instead of BTN selection.
// Revision: 1.0 - initial release
// ============================================================================
module tb_decodificador_display;

`ifdef DECODIFICADOR_SCAN_EN
  localparam int SCAN_W = 4;
`else
  localparam int SCAN_W = 17;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decodificador_display_if io ();

  decodificador_display #(.SCAN_DIV_W(SCAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  // Reference glyphs, {g..a}, active-low, straight from the display table.
  logic [6:0] glyph_tbl [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Bench-side copy of what is currently driven.
  logic [3:0] sw_m [0:3];
  logic [1:0] btn_m;

  function automatic logic [3:0] ref_an(input int digit);
    logic [3:0] a;
    a = 4'b1111;
    a[digit] = 1'b0;
    return a;
  endfunction

  task automatic drive(input logic [1:0] btn, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3);
    btn_m = btn; sw_m[0] = s0; sw_m[1] = s1; sw_m[2] = s2; sw_m[3] = s3;
    io.BTN = btn; io.SW0 = s0; io.SW1 = s1; io.SW2 = s2; io.SW3 = s3;
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'd2, 4'h7, 4'h7, 4'h7, 4'h7);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({io.AN, io.SEG} !== {4'b1111, 7'b1111111}) begin
        errors++;
        $display("FAIL reset_blank cycle %0d: AN=%b SEG=%b expected AN=1111 SEG=1111111", i, io.AN, io.SEG);
      end
    end
    rst = 1'b0;
    drive(2'd0, 4'h3, 4'h0, 4'h0, 4'h0);
    tick();
    checks++;
    if ({io.AN, io.SEG} !== {4'b1110, 7'b0110000}) begin
      errors++;
      $display("FAIL first_decode: AN=%b SEG=%b expected AN=1110 SEG=0110000", io.AN, io.SEG);
    end
  endtask

  // Directed vectors: one pair of values per digit, literal expected results.
  task automatic test_directed();
    logic [1:0] btn_v [0:7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [3:0] val_v [0:7] = '{4'h3, 4'h1, 4'h6, 4'h4, 4'h8, 4'h9, 4'h9, 4'hD};
    logic [3:0] an_v  [0:7] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
                                4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [6:0] seg_v [0:7] = '{7'b0110000, 7'b1111001, 7'b0000010, 7'b0011001,
                                7'b0000000, 7'b0010000, 7'b0010000, 7'b0100001};
    logic [3:0] s [0:3];
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) s[k] = sw_m[k];
      s[btn_v[i]] = val_v[i];
      drive(btn_v[i], s[0], s[1], s[2], s[3]);
      tick();
      checks++;
      if ({io.AN, io.SEG} !== {an_v[i], seg_v[i]}) begin
        errors++;
        $display("FAIL directed_%0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                 i, io.AN, io.SEG, an_v[i], seg_v[i]);
      end
    end
  endtask

  // Changing only non-selected groups must not disturb the outputs.
  task automatic test_unselected();
    logic [3:0] s [0:3];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
      exp_an  = ref_an(btn_m);
      exp_seg = glyph_tbl[sw_m[btn_m]];
      for (int k = 0; k < 4; k++) s[k] = (k == btn_m) ? sw_m[k] : 4'($urandom);
      drive(btn_m, s[0], s[1], s[2], s[3]);
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if ({io.AN, io.SEG} !== {exp_an, exp_seg}) begin
          errors++;
          $display("FAIL unselected_%0d_%0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                   i, c, io.AN, io.SEG, exp_an, exp_seg);
        end
      end
    end
  endtask

  // New BTN and SW values every cycle; each edge must decode the fresh pair.
  task automatic test_back_to_back();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 0; i < 48; i++) begin
      drive(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      exp_an  = ref_an(btn_m);
      exp_seg = glyph_tbl[sw_m[btn_m]];
      tick();
      checks++;
      if ({io.AN, io.SEG} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL back_to_back_%0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                 i, io.AN, io.SEG, exp_an, exp_seg);
      end
      checks++;
      if ($countones(~io.AN) != 1) begin
        errors++;
        $display("FAIL one_anode_%0d: AN=%b expected exactly one low bit", i, io.AN);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    drive(2'd3, 4'h0, 4'h0, 4'h0, 4'hD);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({io.AN, io.SEG} !== {4'b1111, 7'b1111111}) begin
      errors++;
      $display("FAIL mid_reset_blank: AN=%b SEG=%b expected AN=1111 SEG=1111111", io.AN, io.SEG);
    end
    rst = 1'b0;
    drive(2'd1, 4'h0, 4'hA, 4'h0, 4'h0);
    exp_an  = ref_an(btn_m);
    exp_seg = glyph_tbl[sw_m[btn_m]];
    tick();
    checks++;
    if ({io.AN, io.SEG} !== {exp_an, exp_seg}) begin
      errors++;
      $display("FAIL resume_after_reset: AN=%b SEG=%b expected AN=%b SEG=%b",
               io.AN, io.SEG, exp_an, exp_seg);
    end
  endtask

`ifdef DECODIFICADOR_SCAN_EN
  // After reset release, edge k shows digit ((k-1) / 2**SCAN_W) mod 4.
  task automatic test_scan();
    int digit;
    drive(2'd0, 4'h1, 4'h2, 4'h3, 4'h4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      io.BTN = 2'($urandom);
      tick();
      digit = ((k - 1) / (1 << SCAN_W)) % 4;
      checks++;
      if ({io.AN, io.SEG} !== {ref_an(digit), glyph_tbl[sw_m[digit]]}) begin
        errors++;
        $display("FAIL scan_edge_%0d: AN=%b SEG=%b expected AN=%b SEG=%b",
                 k, io.AN, io.SEG, ref_an(digit), glyph_tbl[sw_m[digit]]);
      end
    end
  endtask
`endif

  initial begin
    drive(2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
`ifdef DECODIFICADOR_SCAN_EN
    test_scan();
`else
    test_reset();
    test_directed();
    test_unselected();
    test_back_to_back();
    test_mid_reset();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decodificador_display
`default_nettype wire
